alu_internal_seq: RTL and testbench
===================================

# alu_internal_seq

Micro-sequencer that produces the active-low internal-operation controls (INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC) consumed directly by the ALU control decoders (Ctrl0 and siblings). On a start pulse from the instruction decoder it runs an optional address-calculation phase, then one or more internal MOV/INC/DEC cycles, then signals completion. All control outputs are registered, so the downstream decoders see glitch-free, cycle-aligned controls.

## Interface
- CNT_W, 4, width of the repeat count for INC/DEC.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
- START  in  1  one-cycle request; sampled only in IDLE.
- OP  in  2  00 MOV, 01 INC, 10 DEC, 11 reserved (no internal op).
- ADDR_CALC  in  1  1 = run one ADDR phase before EXEC.
- COUNT  in  CNT_W  INC/DEC repetitions; 0 treated as 1; ignored for MOV.
- STALL  in  1  1 = freeze state, counter and outputs this cycle.
- INTERNAL_MOV  out  1  active-low; low in EXEC for MOV/INC/DEC.
- ADDRESS_MODE  out  1  active-low; low in ADDR.
- INTERNAL_INC_DEC  out  1  active-low; low in EXEC for INC/DEC.
- INTERNAL_DEC  out  1  active-low; low in EXEC for DEC only.
- BUSY  out  1  high in ADDR, EXEC and FIN.
- DONE  out  1  one-cycle pulse in FIN.
- REMAIN  out  CNT_W  EXEC cycles still to run, including the current one.

## Operation
- States: IDLE, ADDR, EXEC, FIN.
- IDLE: START=1 latches OP, ADDR_CALC and COUNT (0 becomes 1; MOV forces 1).
  - Next state is ADDR if ADDR_CALC=1.
  - Otherwise next state is EXEC, or FIN if OP=11.
- ADDR: exactly one non-stalled cycle. Next state is EXEC, or FIN if OP=11.
- EXEC: REMAIN decrements on each non-stalled cycle. When REMAIN=1 and not stalled, next state is FIN.
- FIN: one non-stalled cycle with DONE=1, then IDLE.
- Outputs are registered and decoded from the next state, so the active-low levels are valid for the whole of each state cycle:
  - IDLE/FIN: all four controls = 1.
  - ADDR: ADDRESS_MODE=0, others 1.
  - EXEC MOV: INTERNAL_MOV=0, others 1.
  - EXEC INC: INTERNAL_MOV=0, INTERNAL_INC_DEC=0, others 1.
  - EXEC DEC: INTERNAL_MOV=0, INTERNAL_INC_DEC=0, INTERNAL_DEC=0, ADDRESS_MODE=1.
- START while BUSY=1 is ignored; no queuing.
- STALL=1 holds every register, including DONE and REMAIN. A stalled FIN therefore keeps DONE high for the stall duration.
- STALL in IDLE has no effect; START is still accepted.
- Latched OP, ADDR_CALC and COUNT are unaffected by input changes after acceptance.
- REMAIN = 0 in IDLE, ADDR and FIN.

## Timing
- Reset (RST_N=0, asynchronous): state IDLE; INTERNAL_MOV=ADDRESS_MODE=INTERNAL_INC_DEC=INTERNAL_DEC=1; BUSY=0; DONE=0; REMAIN=0.
- Reset mid-sequence aborts immediately; outputs go inactive without waiting for a clock edge.
- START sampled at edge k gives first active state (ADDR or EXEC) outputs after edge k.
- With no stalls, the sequence occupies (ADDR_CALC + N + 1) cycles before returning to IDLE, where N = effective count (0 for OP=11).
- The next START can be sampled on the edge that leaves FIN only if the block is in IDLE at that edge. Earliest back-to-back START is one cycle after the FIN cycle.
- Arithmetic: REMAIN is an unsigned CNT_W counter. The maximum count of 2^CNT_W−1 must not wrap; effective count 0 never occurs.

## Test plan
- Reset: hold RST_N=0 mid-EXEC (DEC, COUNT=5) -> all controls 1, BUSY=0, REMAIN=0 with no clock edge; after release the block is in IDLE.
- MOV, ADDR_CALC=0, START one cycle -> one cycle of INTERNAL_MOV=0 (other controls 1), then DONE=1 for one cycle, BUSY low after 2 cycles total.
- DEC, ADDR_CALC=1, COUNT=3 -> ADDRESS_MODE=0 for 1 cycle, then 3 cycles of MOV/INC_DEC/DEC all 0 with REMAIN 3,2,1, then DONE; 5 busy cycles.
- INC, COUNT=0, STALL high for 2 cycles in EXEC -> INC controls held 3 cycles, REMAIN stays 1, DONE after stall drops; START pulsed while busy ignored.
- OP=11, ADDR_CALC=1 -> ADDR 1 cycle, FIN 1 cycle, INTERNAL_MOV never low.
- COUNT=15 (CNT_W=4) INC -> exactly 15 EXEC cycles, REMAIN 15 down to 1, no wrap.

Source files
------------

// File: rtl/alu_internal_seq_if.sv
// ============================================================================
// Module   : alu_internal_seq_if
// Brief    : Request/control bundle between instruction decoder and sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_internal_seq_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic             addr_calc;
    logic [CNT_W-1:0] count;
    logic             stall;
    logic             internal_mov;
    logic             address_mode;
    logic             internal_inc_dec;
    logic             internal_dec;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remain;

    modport master (
        output start, op, addr_calc, count, stall,
        input  internal_mov, address_mode, internal_inc_dec, internal_dec,
               busy, done, remain
    );

    modport slave (
        input  start, op, addr_calc, count, stall,
        output internal_mov, address_mode, internal_inc_dec, internal_dec,
               busy, done, remain
    );
endinterface

`default_nettype wire

// File: rtl/alu_internal_seq.sv
// ============================================================================
// Module   : alu_internal_seq
// Brief    : Sequencer producing registered active-low ALU internal-op controls
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_internal_seq #(
    parameter int CNT_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_internal_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_EXEC = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [1:0]       c_OP_MOV  = 2'b00;
    localparam logic [1:0]       c_OP_INC  = 2'b01;
    localparam logic [1:0]       c_OP_DEC  = 2'b10;
    localparam logic [1:0]       c_OP_NONE = 2'b11;
    localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_ZERO    = '0;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [1:0]       w_op_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] w_remain_next;

    logic r_mov, r_addr_mode, r_inc_dec, r_dec, r_busy, r_done;
    logic w_mov, w_addr_mode, w_inc_dec, w_dec, w_busy, w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= c_OP_MOV;
            r_count     <= c_ZERO;
            r_remain    <= c_ZERO;
            r_mov       <= 1'b1;
            r_addr_mode <= 1'b1;
            r_inc_dec   <= 1'b1;
            r_dec       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_op_next;
            r_count     <= w_count_next;
            r_remain    <= w_remain_next;
            r_mov       <= w_mov;
            r_addr_mode <= w_addr_mode;
            r_inc_dec   <= w_inc_dec;
            r_dec       <= w_dec;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    // A stall leaves next == current, so the decoded outputs below also hold.
    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_count_next  = r_count;
        w_remain_next = r_remain;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_op_next    = bus.op;
                    w_count_next = ((bus.op == c_OP_MOV) || (bus.count == c_ZERO))
                                   ? c_ONE : bus.count;
                    if (bus.addr_calc) begin
                        w_state_next = ST_ADDR;
                    end else if (bus.op == c_OP_NONE) begin
                        w_state_next = ST_FIN;
                    end else begin
                        w_state_next  = ST_EXEC;
                        w_remain_next = w_count_next;
                    end
                end
            end
            ST_ADDR: begin
                if (!bus.stall) begin
                    if (r_op == c_OP_NONE) begin
                        w_state_next = ST_FIN;
                    end else begin
                        w_state_next  = ST_EXEC;
                        w_remain_next = r_count;
                    end
                end
            end
            ST_EXEC: begin
                if (!bus.stall) begin
                    if (r_remain <= c_ONE) begin
                        w_state_next  = ST_FIN;
                        w_remain_next = c_ZERO;
                    end else begin
                        w_remain_next = r_remain - c_ONE;
                    end
                end
            end
            ST_FIN: begin
                if (!bus.stall) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_remain_next = c_ZERO;
            end
        endcase
    end

    always_comb begin
        w_mov       = 1'b1;
        w_addr_mode = 1'b1;
        w_inc_dec   = 1'b1;
        w_dec       = 1'b1;
        w_busy      = (w_state_next != ST_IDLE);
        w_done      = (w_state_next == ST_FIN);
        if (w_state_next == ST_ADDR) begin
            w_addr_mode = 1'b0;
        end
        if (w_state_next == ST_EXEC) begin
            w_mov     = 1'b0;
            w_inc_dec = !((w_op_next == c_OP_INC) || (w_op_next == c_OP_DEC));
            w_dec     = !(w_op_next == c_OP_DEC);
        end
    end

    assign bus.internal_mov     = r_mov;
    assign bus.address_mode     = r_addr_mode;
    assign bus.internal_inc_dec = r_inc_dec;
    assign bus.internal_dec     = r_dec;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.remain           = r_remain;

endmodule

`default_nettype wire

// File: tb/tb_alu_internal_seq.sv
// ============================================================================
// Module   : tb_alu_internal_seq
// Brief    : Scoreboard bench for alu_internal_seq
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_internal_seq;

    localparam int CNT_W = 4;
    localparam int S_IDLE = 0;
    localparam int S_ADDR = 1;
    localparam int S_EXEC = 2;
    localparam int S_FIN  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_internal_seq_if #(.CNT_W(CNT_W)) bus();

    alu_internal_seq #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];
    bit         stall_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // {mov, addr_mode, inc_dec, dec, busy, done, remain}
    function automatic logic [9:0] rec(input int st, input logic [1:0] op, input logic [3:0] rem);
        case (st)
            S_ADDR:  rec = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
            S_EXEC:  rec = {1'b0, 1'b1, !((op == 2'b01) || (op == 2'b10)), !(op == 2'b10),
                            1'b1, 1'b0, rem};
            S_FIN:   rec = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0};
            default: rec = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic [9:0] observed();
        observed = {bus.internal_mov, bus.address_mode, bus.internal_inc_dec,
                    bus.internal_dec, bus.busy, bus.done, bus.remain};
    endfunction

    // stall_idx selects which state of the sequence is stalled for stall_len cycles
    task automatic run(input string name, input logic [1:0] op, input logic ac,
                       input logic [3:0] cnt, input int stall_idx, input int stall_len,
                       input bit start_busy, input bit idle_stall);
        int n;
        int idx;
        int reps;
        int st[$];
        int rm[$];
        n = (op == 2'b11) ? 0 : (op == 2'b00) ? 1 : ((cnt == 4'd0) ? 1 : int'(cnt));
        if (ac) begin
            st.push_back(S_ADDR); rm.push_back(0);
        end
        for (int i = n; i >= 1; i--) begin
            st.push_back(S_EXEC); rm.push_back(i);
        end
        st.push_back(S_FIN);  rm.push_back(0);
        st.push_back(S_IDLE); rm.push_back(0);
        for (int j = 0; j < st.size(); j++) begin
            reps = (j == stall_idx) ? stall_len + 1 : 1;
            for (int k = 0; k < reps; k++) begin
                exp_q.push_back(rec(st[j], op, 4'(rm[j])));
                stall_q.push_back(k < reps - 1);
            end
        end
        bus.start     = 1'b1;
        bus.op        = op;
        bus.addr_calc = ac;
        bus.count     = cnt;
        bus.stall     = idle_stall;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            if (idx == 0) begin
                bus.start     = 1'b0;
                bus.op        = 2'($urandom);
                bus.addr_calc = 1'($urandom);
                bus.count     = 4'($urandom);
            end
            if (start_busy) bus.start = (idx == 1);
            bus.stall = stall_q.pop_front();
            check($sformatf("%s[%0d]", name, idx), 32'(observed()), 32'(exp_q.pop_front()));
            idx++;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.addr_calc = 1'b0;
        bus.count     = 4'd0;
        bus.stall     = 1'b0;
        #12;
        check("reset_state", 32'(observed()), 32'(rec(S_IDLE, 2'b00, 4'd0)));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 32'(observed()), 32'(rec(S_IDLE, 2'b00, 4'd0)));

        run("mov",          2'b00, 1'b0, 4'd9,  -1, 0, 1'b0, 1'b0);
        run("dec_addr3",    2'b10, 1'b1, 4'd3,  -1, 0, 1'b0, 1'b0);
        run("inc0_stall",   2'b01, 1'b0, 4'd0,   0, 2, 1'b1, 1'b0);
        run("none_addr",    2'b11, 1'b1, 4'd6,  -1, 0, 1'b0, 1'b0);
        run("inc15",        2'b01, 1'b0, 4'd15, -1, 0, 1'b1, 1'b0);
        run("mov_finstall", 2'b00, 1'b1, 4'd7,   2, 2, 1'b1, 1'b1);
        run("dec_addrstall",2'b10, 1'b1, 4'd2,   0, 1, 1'b0, 1'b0);
        run("none",         2'b11, 1'b0, 4'd1,  -1, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a DEC run
        bus.start     = 1'b1;
        bus.op        = 2'b10;
        bus.addr_calc = 1'b0;
        bus.count     = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_exec", 32'(observed()), 32'(rec(S_EXEC, 2'b10, 4'd4)));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(observed()), 32'(rec(S_IDLE, 2'b00, 4'd0)));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_idle", 32'(observed()), 32'(rec(S_IDLE, 2'b00, 4'd0)));

        run("mov_after_rst", 2'b00, 1'b0, 4'd0, -1, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
